// File: rtl/gain_ramp_ctrl_if.sv
// Control/status bundle between software-facing logic and gain_ramp_ctrl.
// master drives the controls and the multiplier overflow flag; slave is the
// ramp controller itself.
interface gain_ramp_ctrl_if #(
  parameter int GAIN_WIDTH      = 7,
  parameter int DIV_WIDTH       = 16,
  parameter int OFLOW_CNT_WIDTH = 8
);
  logic signed [GAIN_WIDTH-1:0]   gain_target;
  logic                           gain_load;
  logic [DIV_WIDTH-1:0]           ramp_div;
  logic                           backoff_en;
  logic                           overflow;
  logic                           oflow_clr;
  logic signed [GAIN_WIDTH-1:0]   gain;
  logic                           ramping;
  logic                           holding;
  logic [OFLOW_CNT_WIDTH-1:0]     oflow_count;
  logic                           oflow_sticky;

  modport master (
    output gain_target, gain_load, ramp_div, backoff_en, overflow, oflow_clr,
    input  gain, ramping, holding, oflow_count, oflow_sticky
  );

  modport slave (
    input  gain_target, gain_load, ramp_div, backoff_en, overflow, oflow_clr,
    output gain, ramping, holding, oflow_count, oflow_sticky
  );
endinterface

// File: rtl/gain_ramp_ctrl.sv
// Gain ramp controller: walks the signed gain word toward a loaded target one
// step per ramp_div+1 cycles, backs gain off by one step on multiplier
// overflow (then holds), and keeps a saturating overflow count + sticky flag.
module gain_ramp_ctrl #(
  parameter int GAIN_WIDTH      = 7,
  parameter int DIV_WIDTH       = 16,
  parameter int OFLOW_CNT_WIDTH = 8,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  gain_ramp_ctrl_if.slave  bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic signed [GAIN_WIDTH-1:0] ONE = GAIN_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t                       state_q, state_d;
  logic signed [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic signed [GAIN_WIDTH-1:0] tgt_q, tgt_d;
  logic [DIV_WIDTH-1:0]         presc_q, presc_d;
  logic [HW-1:0]                hold_q, hold_d;
  logic                         ovf_q;
  logic [OFLOW_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                         sticky_q, sticky_d;

  // Target seen this cycle: a load strobe overrides the stored target so a
  // retarget steers the very step taken on the same edge.
  logic signed [GAIN_WIDTH-1:0] eff_tgt;
  logic signed [GAIN_WIDTH-1:0] step_gain;
  logic                         backoff;
  logic                         term;

  // State and datapath registers; overflow is registered once before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gain_q   <= '0;
      tgt_q    <= '0;
      presc_q  <= '0;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      tgt_q    <= tgt_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      ovf_q    <= bus.overflow;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Next-state logic: backoff outranks any load; HOLD defers ramping.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    tgt_d    = tgt_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    eff_tgt  = bus.gain_load ? bus.gain_target : tgt_q;
    // Lowering ramp_div below the running count terminates immediately.
    term     = (presc_q >= bus.ramp_div);
    backoff  = bus.backoff_en && ovf_q && (state_q != HOLD);

    if (gain_q < eff_tgt)      step_gain = gain_q + ONE;
    else if (gain_q > eff_tgt) step_gain = gain_q - ONE;
    else                       step_gain = gain_q;

    if (backoff) begin
      // One step toward zero; -64 becomes -63, zero stays zero.
      if (gain_q > 0)      gain_d = gain_q - ONE;
      else if (gain_q < 0) gain_d = gain_q + ONE;
      tgt_d   = gain_d;
      hold_d  = HOLD_INIT;
      state_d = HOLD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.gain_load) begin
            tgt_d   = bus.gain_target;
            presc_d = '0;
            if (bus.gain_target != gain_q) state_d = RAMP;
          end
        end
        RAMP: begin
          tgt_d = eff_tgt;
          if (eff_tgt == gain_q) begin
            state_d = IDLE;
          end else if (term) begin
            presc_d = '0;
            gain_d  = step_gain;
            if (step_gain == eff_tgt) state_d = IDLE;
          end else begin
            presc_d = presc_q + DIV_WIDTH'(1);
          end
        end
        HOLD: begin
          tgt_d = eff_tgt;
          if (hold_q == '0) begin
            presc_d = '0;
            state_d = (eff_tgt != gain_q) ? RAMP : IDLE;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over history but not over an overflow in the same cycle.
    if (bus.oflow_clr) begin
      cnt_d    = ovf_q ? OFLOW_CNT_WIDTH'(1) : '0;
      sticky_d = ovf_q;
    end else if (ovf_q) begin
      if (!(&cnt_q)) cnt_d = cnt_q + OFLOW_CNT_WIDTH'(1);
      sticky_d = 1'b1;
    end
  end

  assign bus.gain         = gain_q;
  assign bus.ramping      = (state_q == RAMP);
  assign bus.holding      = (state_q == HOLD);
  assign bus.oflow_count  = cnt_q;
  assign bus.oflow_sticky = sticky_q;

endmodule

// File: doc/gain_ramp_ctrl.md
Name: gain_ramp_ctrl

Overview:
- Control-side partner of the gain multiplier.
- Produces the signed 7-bit gain word that feeds the multiplier's gain input, and consumes the multiplier's overflow flag.
- Ramps gain toward a software-written target at a programmable rate, so the DAC output never sees a step.
- Optionally backs gain off automatically on overflow, and keeps a saturating overflow event count plus a sticky flag for readback.

Parameters:
- GAIN_WIDTH, 7: width of signed gain word; range -64..+63.
- DIV_WIDTH, 16: width of ramp prescaler and ramp_div port.
- OFLOW_CNT_WIDTH, 8: width of saturating overflow counter.
- HOLD_CYCLES, 1024: post-backoff hold time in clk cycles; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- gain_target  input  GAIN_WIDTH  signed target gain; sampled only when gain_load=1.
- gain_load  input  1  single-cycle strobe that latches gain_target.
- ramp_div  input  DIV_WIDTH  step period minus one: one gain step every ramp_div+1 cycles.
- backoff_en  input  1  enables automatic gain backoff on overflow.
- overflow  input  1  overflow flag from the multiplier; level, 1 per overflowing sample.
- oflow_clr  input  1  strobe; clears oflow_count and oflow_sticky.
- gain  output  GAIN_WIDTH  signed gain word to the multiplier; registered.
- ramping  output  1  high while the FSM is in RAMP.
- holding  output  1  high while the FSM is in HOLD.
- oflow_count  output  OFLOW_CNT_WIDTH  overflow cycles seen; saturates at all-ones.
- oflow_sticky  output  1  set by any overflow; cleared only by oflow_clr or rst.

Behaviour:
- Reset: gain=0, target register tgt=0, prescaler=0, overflow_q=0, state=IDLE, ramping=0, holding=0, oflow_count=0, oflow_sticky=0. Reset mid-ramp or mid-hold aborts immediately to these values.
- Input registering: overflow is registered once into overflow_q. All overflow actions occur on the edge after overflow_q=1. Total latency from overflow high to gain change is 2 edges.
- FSM states: IDLE, RAMP, HOLD.
- IDLE:
  - On gain_load: tgt<=gain_target and prescaler<=0.
  - If gain_target != gain, next state is RAMP; otherwise stay in IDLE.
- RAMP:
  - Prescaler counts 0..ramp_div.
  - At terminal count: prescaler<=0 and gain<=gain±1 toward tgt.
  - If gain reaches tgt, go to IDLE on the same edge.
  - ramp_div=0 gives one step per cycle. A 0->63 ramp then takes 63 cycles.
  - gain_load during RAMP retargets tgt without resetting the prescaler. A retarget equal to the current gain goes to IDLE on the next edge.
- Backoff (backoff_en=1 and overflow_q=1, in IDLE or RAMP):
  - gain moves one step toward 0, unless gain=0.
  - tgt<=new gain.
  - hold counter<=HOLD_CYCLES-1; state<=HOLD.
  - gain=-64 backs off to -63.
- HOLD:
  - Hold counter decrements; no further backoff occurs, but overflows are still counted.
  - gain_load updates tgt only; the ramp is deferred.
  - When the counter reaches 0: go to RAMP if tgt != gain, else IDLE. Prescaler<=0.
- With backoff_en=0, overflow affects only the counter and sticky flag; gain is untouched.
- Priority in one cycle: rst > backoff > gain_load. A gain_load coincident with an applied backoff is discarded.
- Counter: increments by 1 on every edge where overflow_q=1 and stops at 2^OFLOW_CNT_WIDTH-1. With oflow_clr and overflow_q both 1 in the same cycle, the result is count=1 and sticky=1.
- Arithmetic: gain stays within -64..+63; a step never overshoots tgt. ramp_div is read live each cycle. If ramp_div is lowered below the current prescaler value, the terminal condition is prescaler>=ramp_div.

Test Plan:
- Ramp up: rst, ramp_div=3, load target=+10 -> gain steps 0,1,...,10, one step every 4 clk; ramping=1 for 40 cycles, then IDLE; gain holds at 10.
- Ramp down with retarget: from gain=10, load -5 with ramp_div=0; after 4 steps (gain=6) load +8 -> gain 6,7,8, then IDLE. gain never goes below 6 after the retarget.
- Backoff: gain=20 in IDLE, backoff_en=1, HOLD_CYCLES=16, overflow high 1 cycle -> gain=19 two edges later; holding=1 for 16 cycles; a second overflow during hold leaves gain=19 and makes count=2; state returns to IDLE.
- Load in hold: during hold, load 30 -> gain stays 19 until hold expires, then ramps 19->30.
- Counter saturation/clear: overflow held high 300 cycles with backoff_en=0 -> oflow_count=255, sticky=1, gain unchanged. oflow_clr coincident with overflow_q=1 -> count=1. oflow_clr alone -> count=0, sticky=0.
- Limits and reset: load -64 with ramp_div=0 -> gain reaches -64; an overflow with backoff_en=1 gives -63. Assert rst mid-ramp -> next edge gain=0, all outputs at reset values.
